// File: rtl/pipe_controller.sv
// Purpose: D-stage decoder plus E/M/W control pipeline and saturating retired-instruction counter.
// Latency: D decode is combinational; controls reach W exactly 3 edges after D (no stall/flush).
// Backpressure: stallE holds E and injects a bubble into M; flushE bubbles E (wins over stallE).
//
// Ports: clk/rst_n (async active-low); op/funct/validD from D; stallE/flushE hazard controls;
//        cntClr clears retCnt; D decode outputs (branchD..illegalD); E/M/W control outputs; retCnt.
// Optional build macro: PIPE_CTRL_EXT_ISA_EN adds ANDI/ORI/SLTI/BNE to the legal opcode set.
module pipe_controller #(
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              validD,
    input  logic              stallE,
    input  logic              flushE,
    input  logic              cntClr,
    output logic              branchD,
    output logic              branchNeD,
    output logic              jumpD,
    output logic              zeroExtD,
    output logic              illegalD,
    output logic              regWriteE,
    output logic              memToRegE,
    output logic              memWriteE,
    output logic              aluSrcE,
    output logic              regDstE,
    output logic              validE,
    output logic [ALUC_W-1:0] aluControlE,
    output logic              regWriteM,
    output logic              memToRegM,
    output logic              memWriteM,
    output logic              validM,
    output logic              regWriteW,
    output logic              memToRegW,
    output logic              validW,
    output logic [CNT_W-1:0]  retCnt
);

    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b000);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b001);
    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b110);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b111);

    logic              dec_rw, dec_mtr, dec_mw, dec_asrc, dec_rd;
    logic              dec_br, dec_j, dec_ill;
    logic [ALUC_W-1:0] dec_alu;
`ifdef PIPE_CTRL_EXT_ISA_EN
    logic              dec_bne, dec_zx;
`endif
    logic              cap_vld;

    // Raw decode, independent of validD; illegal encodings collapse to a bubble.
    always_comb begin
        dec_rw   = 1'b0;
        dec_mtr  = 1'b0;
        dec_mw   = 1'b0;
        dec_asrc = 1'b0;
        dec_rd   = 1'b0;
        dec_br   = 1'b0;
        dec_j    = 1'b0;
        dec_ill  = 1'b0;
        dec_alu  = ALU_ADD;
`ifdef PIPE_CTRL_EXT_ISA_EN
        dec_bne  = 1'b0;
        dec_zx   = 1'b0;
`endif
        case (op)
            6'b000000: begin
                dec_rw = 1'b1;
                dec_rd = 1'b1;
                case (funct)
                    6'b100000: dec_alu = ALU_ADD;
                    6'b100010: dec_alu = ALU_SUB;
                    6'b100100: dec_alu = ALU_AND;
                    6'b100101: dec_alu = ALU_OR;
                    6'b101010: dec_alu = ALU_SLT;
                    default:   dec_ill = 1'b1;
                endcase
            end
            6'b100011: begin dec_rw = 1'b1; dec_asrc = 1'b1; dec_mtr = 1'b1; end
            6'b101011: begin dec_asrc = 1'b1; dec_mw = 1'b1; end
            6'b000100: begin dec_br = 1'b1; dec_alu = ALU_SUB; end
            6'b001000: begin dec_rw = 1'b1; dec_asrc = 1'b1; end
            6'b000010: dec_j = 1'b1;
`ifdef PIPE_CTRL_EXT_ISA_EN
            6'b001100: begin dec_rw = 1'b1; dec_asrc = 1'b1; dec_zx = 1'b1; dec_alu = ALU_AND; end
            6'b001101: begin dec_rw = 1'b1; dec_asrc = 1'b1; dec_zx = 1'b1; dec_alu = ALU_OR; end
            6'b001010: begin dec_rw = 1'b1; dec_asrc = 1'b1; dec_alu = ALU_SLT; end
            6'b000101: begin dec_bne = 1'b1; dec_alu = ALU_SUB; end
`endif
            default:   dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_rw   = 1'b0;
            dec_mtr  = 1'b0;
            dec_mw   = 1'b0;
            dec_asrc = 1'b0;
            dec_rd   = 1'b0;
            dec_br   = 1'b0;
            dec_j    = 1'b0;
            dec_alu  = ALU_ADD;
`ifdef PIPE_CTRL_EXT_ISA_EN
            dec_bne  = 1'b0;
            dec_zx   = 1'b0;
`endif
        end
    end

    assign branchD  = validD & dec_br;
    assign jumpD    = validD & dec_j;
    assign illegalD = validD & dec_ill;
`ifdef PIPE_CTRL_EXT_ISA_EN
    assign branchNeD = validD & dec_bne;
    assign zeroExtD  = validD & dec_zx;
`else
    assign branchNeD = 1'b0;
    assign zeroExtD  = 1'b0;
`endif

    // Only a valid, legal instruction may carry write enables into the pipe.
    assign cap_vld = validD & ~dec_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWriteE   <= 1'b0;
            memToRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            aluSrcE     <= 1'b0;
            regDstE     <= 1'b0;
            validE      <= 1'b0;
            aluControlE <= '0;
        end else if (flushE) begin
            regWriteE   <= 1'b0;
            memToRegE   <= 1'b0;
            memWriteE   <= 1'b0;
            aluSrcE     <= 1'b0;
            regDstE     <= 1'b0;
            validE      <= 1'b0;
            aluControlE <= '0;
        end else if (!stallE) begin
            regWriteE   <= cap_vld & dec_rw;
            memToRegE   <= cap_vld & dec_mtr;
            memWriteE   <= cap_vld & dec_mw;
            aluSrcE     <= cap_vld & dec_asrc;
            regDstE     <= cap_vld & dec_rd;
            validE      <= cap_vld;
            aluControlE <= validD ? dec_alu : '0;
        end
    end

    // While E is held, its contents must not also advance, so M takes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWriteM <= 1'b0;
            memToRegM <= 1'b0;
            memWriteM <= 1'b0;
            validM    <= 1'b0;
        end else if (stallE && !flushE) begin
            regWriteM <= 1'b0;
            memToRegM <= 1'b0;
            memWriteM <= 1'b0;
            validM    <= 1'b0;
        end else begin
            regWriteM <= regWriteE;
            memToRegM <= memToRegE;
            memWriteM <= memWriteE;
            validM    <= validE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            validW    <= 1'b0;
        end else begin
            regWriteW <= regWriteM;
            memToRegW <= memToRegM;
            validW    <= validM;
        end
    end

    // Saturating retire counter; clear wins over a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retCnt <= '0;
        end else if (cntClr) begin
            retCnt <= '0;
        end else if (validW && (retCnt != {CNT_W{1'b1}})) begin
            retCnt <= retCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_controller.sv
module tb_pipe_controller;

`ifdef PIPE_CTRL_EXT_ISA_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] op, funct;
    logic validD, stallE, flushE, cntClr;

    logic branchD, branchNeD, jumpD, zeroExtD, illegalD;
    logic regWriteE, memToRegE, memWriteE, aluSrcE, regDstE, validE;
    logic [2:0] aluControlE;
    logic regWriteM, memToRegM, memWriteM, validM;
    logic regWriteW, memToRegW, validW;
    logic [15:0] retCnt;

    logic branchD2, branchNeD2, jumpD2, zeroExtD2, illegalD2;
    logic regWriteE2, memToRegE2, memWriteE2, aluSrcE2, regDstE2, validE2;
    logic [2:0] aluControlE2;
    logic regWriteM2, memToRegM2, memWriteM2, validM2;
    logic regWriteW2, memToRegW2, validW2;
    logic [1:0] retCnt2;

    pipe_controller #(.ALUC_W(3), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .validD(validD),
        .stallE(stallE), .flushE(flushE), .cntClr(cntClr),
        .branchD(branchD), .branchNeD(branchNeD), .jumpD(jumpD), .zeroExtD(zeroExtD), .illegalD(illegalD),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE), .aluSrcE(aluSrcE),
        .regDstE(regDstE), .validE(validE), .aluControlE(aluControlE),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM), .validM(validM),
        .regWriteW(regWriteW), .memToRegW(memToRegW), .validW(validW), .retCnt(retCnt));

    pipe_controller #(.ALUC_W(3), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .validD(validD),
        .stallE(stallE), .flushE(flushE), .cntClr(cntClr),
        .branchD(branchD2), .branchNeD(branchNeD2), .jumpD(jumpD2), .zeroExtD(zeroExtD2), .illegalD(illegalD2),
        .regWriteE(regWriteE2), .memToRegE(memToRegE2), .memWriteE(memWriteE2), .aluSrcE(aluSrcE2),
        .regDstE(regDstE2), .validE(validE2), .aluControlE(aluControlE2),
        .regWriteM(regWriteM2), .memToRegM(memToRegM2), .memWriteM(memWriteM2), .validM(validM2),
        .regWriteW(regWriteW2), .memToRegW(memToRegW2), .validW(validW2), .retCnt(retCnt2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic rw, mtr, mw, asrc, rd, v;
        logic [2:0] alu;
        logic br, bne, j, zx, ill;
    } dec_t;

    dec_t e_m, m_m, w_m;
    int cnt_m, cnt2_m;

    // Reference decode straight from the opcode/funct table.
    function automatic dec_t ref_dec(input logic [5:0] o, input logic [5:0] f, input logic vd);
        dec_t d;
        d = '0;
        d.alu = 3'b010;
        case (o)
            6'b000000: begin
                d.rw = 1'b1; d.rd = 1'b1;
                case (f)
                    6'b100000: d.alu = 3'b010;
                    6'b100010: d.alu = 3'b110;
                    6'b100100: d.alu = 3'b000;
                    6'b100101: d.alu = 3'b001;
                    6'b101010: d.alu = 3'b111;
                    default:   d.ill = 1'b1;
                endcase
            end
            6'b100011: begin d.rw = 1'b1; d.asrc = 1'b1; d.mtr = 1'b1; end
            6'b101011: begin d.asrc = 1'b1; d.mw = 1'b1; end
            6'b000100: begin d.br = 1'b1; d.alu = 3'b110; end
            6'b001000: begin d.rw = 1'b1; d.asrc = 1'b1; end
            6'b000010: d.j = 1'b1;
            6'b001100: if (EXT) begin d.rw = 1'b1; d.asrc = 1'b1; d.zx = 1'b1; d.alu = 3'b000; end else d.ill = 1'b1;
            6'b001101: if (EXT) begin d.rw = 1'b1; d.asrc = 1'b1; d.zx = 1'b1; d.alu = 3'b001; end else d.ill = 1'b1;
            6'b001010: if (EXT) begin d.rw = 1'b1; d.asrc = 1'b1; d.alu = 3'b111; end else d.ill = 1'b1;
            6'b000101: if (EXT) begin d.bne = 1'b1; d.alu = 3'b110; end else d.ill = 1'b1;
            default:   d.ill = 1'b1;
        endcase
        if (d.ill) begin
            d = '0;
            d.ill = 1'b1;
        end
        d.v = !d.ill;
        if (!vd) d = '0;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_m = '0; m_m = '0; w_m = '0;
        cnt_m = 0; cnt2_m = 0;
    endtask

    task automatic model_adv();
        if (cntClr) begin
            cnt_m = 0; cnt2_m = 0;
        end else if (w_m.v) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt2_m < 3) cnt2_m++;
        end
        w_m = m_m;
        m_m = (stallE && !flushE) ? '0 : e_m;
        if (flushE) e_m = '0;
        else if (!stallE) e_m = ref_dec(op, funct, validD);
    endtask

    task automatic check_d();
        dec_t d;
        d = ref_dec(op, funct, validD);
        chk("decD", {branchD, branchNeD, jumpD, zeroExtD, illegalD}, {d.br, d.bne, d.j, d.zx, d.ill});
        chk("decD2", {branchD2, branchNeD2, jumpD2, zeroExtD2, illegalD2}, {d.br, d.bne, d.j, d.zx, d.ill});
    endtask

    task automatic check_pipe();
        chk("E", {regWriteE, memToRegE, memWriteE, aluSrcE, regDstE, validE},
            {e_m.rw, e_m.mtr, e_m.mw, e_m.asrc, e_m.rd, e_m.v});
        chk("E2", {regWriteE2, memToRegE2, memWriteE2, aluSrcE2, regDstE2, validE2},
            {e_m.rw, e_m.mtr, e_m.mw, e_m.asrc, e_m.rd, e_m.v});
        if (e_m.v) chk("aluE", aluControlE, e_m.alu);
        chk("M", {regWriteM, memToRegM, memWriteM, validM}, {m_m.rw, m_m.mtr, m_m.mw, m_m.v});
        chk("M2", {regWriteM2, memToRegM2, memWriteM2, validM2}, {m_m.rw, m_m.mtr, m_m.mw, m_m.v});
        chk("W", {regWriteW, memToRegW, validW}, {w_m.rw, w_m.mtr, w_m.v});
        chk("W2", {regWriteW2, memToRegW2, validW2}, {w_m.rw, w_m.mtr, w_m.v});
        chk("cnt", retCnt, cnt_m);
        chk("cnt2", retCnt2, cnt2_m);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {regWriteE, memToRegE, memWriteE, aluSrcE, regDstE, validE, aluControlE,
                 regWriteM, memToRegM, memWriteM, validM, regWriteW, memToRegW, validW}, 0);
        chk({nm, "_cnt"}, retCnt, 0);
        chk({nm, "_u2"}, {validE2, aluControlE2, validM2, validW2, retCnt2}, 0);
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic vd,
                         input logic st, input logic fl, input logic clr);
        op = o; funct = f; validD = vd; stallE = st; flushE = fl; cntClr = clr;
    endtask

    // Called at a negedge: decode check, one edge, then registered-output check at the next negedge.
    task automatic step();
        #1 check_d();
        @(posedge clk);
        model_adv();
        @(negedge clk);
        check_pipe();
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic vd;
        logic [4:0] dexp;   // {branch, branchNe, jump, zeroExt, illegal}
        logic vE;
        logic rwE;
        logic [2:0] aluE;
        string nm;
    } vec_t;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_ADDI = 6'b001000;

    vec_t tbl[17];
    logic [5:0] opl[12];
    logic [5:0] fl_list[5];
    int exp2[8];

    initial begin
        tbl[0]  = '{6'b000000, 6'b100000, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b010, "r_add"};
        tbl[1]  = '{6'b000000, 6'b100010, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b110, "r_sub"};
        tbl[2]  = '{6'b000000, 6'b100100, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b000, "r_and"};
        tbl[3]  = '{6'b000000, 6'b100101, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b001, "r_or"};
        tbl[4]  = '{6'b000000, 6'b101010, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b111, "r_slt"};
        tbl[5]  = '{6'b000000, 6'b000111, 1'b1, 5'b00001, 1'b0, 1'b0, 3'b010, "r_bad"};
        tbl[6]  = '{OP_LW,     6'b000000, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b010, "lw"};
        tbl[7]  = '{OP_SW,     6'b111111, 1'b1, 5'b00000, 1'b1, 1'b0, 3'b010, "sw"};
        tbl[8]  = '{6'b000100, 6'b000000, 1'b1, 5'b10000, 1'b1, 1'b0, 3'b110, "beq"};
        tbl[9]  = '{OP_ADDI,   6'b000000, 1'b1, 5'b00000, 1'b1, 1'b1, 3'b010, "addi"};
        tbl[10] = '{6'b000010, 6'b000000, 1'b1, 5'b00100, 1'b1, 1'b0, 3'b010, "j"};
        tbl[11] = '{6'b001100, 6'b000000, 1'b1, EXT ? 5'b00010 : 5'b00001, EXT, EXT, 3'b000, "andi"};
        tbl[12] = '{6'b001101, 6'b000000, 1'b1, EXT ? 5'b00010 : 5'b00001, EXT, EXT, 3'b001, "ori"};
        tbl[13] = '{6'b001010, 6'b000000, 1'b1, EXT ? 5'b00000 : 5'b00001, EXT, EXT, 3'b111, "slti"};
        tbl[14] = '{6'b000101, 6'b000000, 1'b1, EXT ? 5'b01000 : 5'b00001, EXT, 1'b0, 3'b110, "bne"};
        tbl[15] = '{6'b111111, 6'b100000, 1'b1, 5'b00001, 1'b0, 1'b0, 3'b010, "bad_op"};
        tbl[16] = '{OP_LW,     6'b000000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'b010, "lw_invalid"};

        opl = '{6'b000000, OP_LW, OP_SW, 6'b000100, OP_ADDI, 6'b000010,
                6'b001100, 6'b001101, 6'b001010, 6'b000101, 6'b000000, 6'b111000};
        fl_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        exp2 = '{0, 0, 0, 1, 2, 3, 3, 0};

        // Asynchronous reset with an LW sitting in D.
        rst_n = 1'b1;
        drive(OP_LW, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst_lw_W", {regWriteW, memToRegW}, 2'b11);
        step();
        chk("rst_lw_cnt", retCnt, 1);

        // Decode table.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].op, tbl[i].funct, tbl[i].vd, 1'b0, 1'b0, 1'b0);
            #1 chk({"tbl_d_", tbl[i].nm}, {branchD, branchNeD, jumpD, zeroExtD, illegalD}, tbl[i].dexp);
            step();
            chk({"tbl_e_", tbl[i].nm}, {validE, regWriteE}, {tbl[i].vE, tbl[i].rwE});
            if (tbl[i].vE) chk({"tbl_alu_", tbl[i].nm}, aluControlE, tbl[i].aluE);
        end

        // SW held in E by a two-cycle stall.
        drive(OP_SW, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(6'b0, 6'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step();
            chk("stall_mwE", memWriteE, 1);
            chk("stall_mwM", memWriteM, 0);
        end
        drive(6'b0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("stall_rel_mwM", memWriteM, 1);
        step();
        chk("stall_once_mwM", memWriteM, 0);

        // Stall and flush together: flush wins.
        drive(OP_ADDI, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(OP_ADDI, 6'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("stfl_E", {validE, regWriteE}, 2'b00);

        // Two-bit counter saturation and clear-overrides-increment.
        drive(6'b0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        chk("sat_start", retCnt2, 0);
        for (int k = 0; k < 8; k++) begin
            drive(k < 5 ? OP_ADDI : 6'b0, 6'b0, k < 5, 1'b0, 1'b0, k == 7);
            if (k == 7) chk("sat_clr_vW", validW2, 1);
            step();
            chk($sformatf("sat_cnt%0d", k), retCnt2, exp2[k]);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opl[$urandom_range(0, 11)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl_list[$urandom_range(0, 4)];
            drive(o, f, $urandom_range(0, 5) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            step();
            // Mid-stream async reset, no clock edge while asserted.
            if (n == 200) begin
                rst_n = 1'b0;
                #1 chk_all_zero("rst_mid");
                model_reset();
                #1 rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
